// File: rtl/er_pkg.sv
// Shared types and sizes for the ER admission controller and the prioq word it drives.
// The ID pool size and priority width are fixed here so both sides agree on the word layout.
package er_pkg;

   localparam int ID_W   = 2;
   localparam int PRIO_W = 2;
   localparam int NUM_ID = 2 ** ID_W;
   localparam int WORD_W = PRIO_W + ID_W;

   // Word exchanged with prioq: priority in the upper bits so prioq can order on it directly.
   typedef struct packed {
      logic [PRIO_W-1:0] prio;
      logic [ID_W-1:0]   id;
   } patient_t;

   typedef enum logic [1:0] {
      FREE     = 2'd0,
      WAITING  = 2'd1,
      TREATING = 2'd2
   } id_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENQ  = 2'd1,
      DEQ  = 2'd2,
      WAIT = 2'd3
   } fsm_state_t;

endpackage

// File: rtl/er_id_alloc.sv
// Per-ID status table for the ER room: lowest-free allocation, dispatch and discharge
// updates, occupancy/waiting counts and illegal-discharge detection.
module er_id_alloc
   import er_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc,
   input  logic            dispatch,
   input  logic [ID_W-1:0] dispatch_id,
   input  logic            discharge,
   input  logic [ID_W-1:0] discharge_id,
   output logic            free_avail,
   output logic [ID_W-1:0] free_id,
   output logic [ID_W:0]   occ_count,
   output logic [ID_W:0]   wait_count,
   output logic            err
);

   localparam int CW = ID_W + 1;

   id_state_t status [NUM_ID];
   logic      dis_ok;

   // Descending scan so the last hit, the lowest-numbered FREE ID, wins.
   always_comb begin
      free_avail = 1'b0;
      free_id    = '0;
      for (int i = NUM_ID - 1; i >= 0; i--) begin
         if (status[i] == FREE) begin
            free_avail = 1'b1;
            free_id    = ID_W'(i);
         end
      end
   end

   assign dis_ok = discharge && (status[discharge_id] == TREATING);

   // Alloc picks a FREE ID, dispatch moves a WAITING one and discharge frees a TREATING one,
   // so the three updates can never target the same entry in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ID; i++) begin
            status[i] <= FREE;
         end
         occ_count  <= '0;
         wait_count <= '0;
         err        <= 1'b0;
      end else begin
         err <= discharge && !dis_ok;
         if (dis_ok) begin
            status[discharge_id] <= FREE;
         end
         if (dispatch) begin
            status[dispatch_id] <= TREATING;
         end
         if (alloc) begin
            status[free_id] <= WAITING;
         end
         occ_count  <= occ_count + CW'(alloc) - CW'(dis_ok);
         wait_count <= wait_count + CW'(alloc) - CW'(dispatch);
      end
   end

endmodule

// File: rtl/er_admit_ctrl.sv
// ER admission controller: admits patients into prioq, arbitrates doctor requests against
// arrivals, captures the dequeued patient after the prioq latency and reports the dispatch.
module er_admit_ctrl
   import er_pkg::*;
#(
   parameter int DEQ_LAT = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              arr_valid,
   input  logic [PRIO_W-1:0] arr_prio,
   output logic              arr_ready,
   output logic [ID_W-1:0]   arr_id,
   input  logic              doc_req,
   input  logic              dis_valid,
   input  logic [ID_W-1:0]   dis_id,
   output logic [WORD_W-1:0] q_in,
   output logic              q_ende,
   output logic              q_op,
   input  logic [WORD_W-1:0] q_out,
   output logic              disp_valid,
   output logic [PRIO_W-1:0] disp_prio,
   output logic [ID_W-1:0]   disp_id,
   output logic [ID_W:0]     occ_count,
   output logic [ID_W:0]     wait_count,
   output logic              full,
   output logic              err
);

   fsm_state_t state;
   logic       doc_pending;
   logic [1:0] lat_cnt;
   logic       deq_grant;
   logic       arr_acc;
   logic       capture;
   logic       free_avail;
   logic [ID_W-1:0] free_id;
   patient_t   q_word;

   assign q_word = patient_t'(q_out);

   // Dequeue wins over a simultaneous arrival; arr_ready drops in that cycle.
   assign deq_grant = (state == IDLE) && (doc_req || doc_pending) && (wait_count != '0);
   assign arr_ready = (state == IDLE) && !full && !deq_grant;
   assign arr_acc   = arr_valid && arr_ready;
   assign arr_id    = free_id;
   assign full      = (occ_count == (ID_W + 1)'(NUM_ID));
   assign capture   = (state == WAIT) && (lat_cnt == 2'd0);

   er_id_alloc u_id_alloc (
      .clk          (clk),
      .rst          (rst),
      .alloc        (arr_acc),
      .dispatch     (capture),
      .dispatch_id  (q_word.id),
      .discharge    (dis_valid),
      .discharge_id (dis_id),
      .free_avail   (free_avail),
      .free_id      (free_id),
      .occ_count    (occ_count),
      .wait_count   (wait_count),
      .err          (err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         doc_pending <= 1'b0;
         lat_cnt     <= 2'd0;
         q_op        <= 1'b0;
         q_ende      <= 1'b0;
         q_in        <= '0;
         disp_valid  <= 1'b0;
         disp_prio   <= '0;
         disp_id     <= '0;
      end else begin
         q_op       <= 1'b0;
         q_ende     <= 1'b0;
         q_in       <= '0;
         disp_valid <= 1'b0;

         // Requests that cannot be served now collapse into a single pending flag.
         if (deq_grant) begin
            doc_pending <= 1'b0;
         end else if (doc_req) begin
            doc_pending <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (deq_grant) begin
                  state  <= DEQ;
                  q_op   <= 1'b1;
                  q_ende <= 1'b1;
               end else if (arr_acc) begin
                  state <= ENQ;
                  q_op  <= 1'b1;
                  q_in  <= {arr_prio, free_id};
               end
            end
            ENQ: begin
               state <= IDLE;
            end
            DEQ: begin
               state   <= WAIT;
               lat_cnt <= 2'(DEQ_LAT - 1);
            end
            WAIT: begin
               if (lat_cnt == 2'd0) begin
                  state      <= IDLE;
                  disp_valid <= 1'b1;
                  disp_prio  <= q_word.prio;
                  disp_id    <= q_word.id;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_er_admit_ctrl.sv
// Bench for er_admit_ctrl: a behavioural prioq plus a set-based reference model of the
// room, driven by a directed vector table, hand sequences and random traffic.
module tb_er_admit_ctrl;
   import er_pkg::*;

   localparam int DEQ_LAT = 1;
   typedef logic [WORD_W-1:0] word_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              arr_valid = 1'b0;
   logic [PRIO_W-1:0] arr_prio = '0;
   logic              doc_req = 1'b0;
   logic              dis_valid = 1'b0;
   logic [ID_W-1:0]   dis_id = '0;
   logic              arr_ready, q_ende, q_op, disp_valid, full, err;
   logic [ID_W-1:0]   arr_id, disp_id;
   logic [PRIO_W-1:0] disp_prio;
   word_t             q_in, q_out;
   logic [ID_W:0]     occ_count, wait_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   er_admit_ctrl #(.DEQ_LAT(DEQ_LAT)) dut (
      .clk(clk), .rst(rst), .arr_valid(arr_valid), .arr_prio(arr_prio), .arr_ready(arr_ready),
      .arr_id(arr_id), .doc_req(doc_req), .dis_valid(dis_valid), .dis_id(dis_id), .q_in(q_in),
      .q_ende(q_ende), .q_op(q_op), .q_out(q_out), .disp_valid(disp_valid), .disp_prio(disp_prio),
      .disp_id(disp_id), .occ_count(occ_count), .wait_count(wait_count), .full(full), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Highest priority wins; among equals the earliest enqueued.
   function automatic int pick_max(input word_t q[$]);
      int best = 0;
      for (int i = 1; i < q.size(); i++) begin
         if (q[i][WORD_W-1:ID_W] > q[best][WORD_W-1:ID_W]) best = i;
      end
      return best;
   endfunction

   // Behavioural prioq: out word appears DEQ_LAT cycles after the dequeue strobe.
   word_t pq[$];
   word_t pipe[DEQ_LAT];
   assign q_out = pipe[DEQ_LAT-1];
   always @(posedge clk) begin
      if (rst) begin
         pq.delete();
      end else if (q_op && !q_ende) begin
         pq.push_back(q_in);
      end else if (q_op && q_ende && pq.size() > 0) begin
         int k;
         k = pick_max(pq);
         pipe[0] <= pq[k];
         pq.delete(k);
      end
      for (int i = 1; i < DEQ_LAT; i++) pipe[i] <= pipe[i-1];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Reference model: ID states as a plain array (0 free, 1 waiting, 2 treating), counts
   // derived by counting, plus a busy window and the patient in flight to a doctor.
   int    m_st[NUM_ID];
   word_t m_pq[$];
   int    m_busy, m_deq_left;
   bit    m_pend;
   logic  m_q_op, m_q_ende, m_dv, m_err;
   word_t m_q_in, m_inflight;
   logic [PRIO_W-1:0] m_dp;
   logic [ID_W-1:0]   m_di;

   function automatic int m_count(input int s);
      int n = 0;
      for (int i = 0; i < NUM_ID; i++) if (m_st[i] == s) n++;
      return n;
   endfunction

   function automatic int m_lowest();
      for (int i = 0; i < NUM_ID; i++) if (m_st[i] == 0) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_ID; i++) m_st[i] = 0;
      m_pq.delete();
      m_busy = 0; m_deq_left = 0; m_pend = 0;
      m_q_op = 0; m_q_ende = 0; m_q_in = '0; m_dv = 0; m_err = 0;
      m_dp = '0; m_di = '0; m_inflight = '0;
   endtask

   task automatic model_comb(output bit rdy, output bit grant, output int low);
      low   = m_lowest();
      grant = (m_busy == 0) && (doc_req || m_pend) && (m_count(1) > 0);
      rdy   = (m_busy == 0) && (low >= 0) && !grant;
   endtask

   task automatic model_check();
      bit rdy, grant;
      int low;
      model_comb(rdy, grant, low);
      chk("arr_ready", arr_ready, rdy);
      if (rdy) chk("arr_id", arr_id, low);
      chk("q_op", q_op, m_q_op);
      chk("q_ende", q_ende, m_q_ende);
      chk("q_in", q_in, m_q_in);
      chk("disp_valid", disp_valid, m_dv);
      chk("disp_prio", disp_prio, m_dp);
      chk("disp_id", disp_id, m_di);
      chk("occ_count", occ_count, m_count(1) + m_count(2));
      chk("wait_count", wait_count, m_count(1));
      chk("full", full, m_count(0) == 0);
      chk("err", err, m_err);
   endtask

   task automatic model_advance();
      bit rdy, grant;
      int low, idx;
      model_comb(rdy, grant, low);
      m_q_op = 0; m_q_ende = 0; m_q_in = '0; m_dv = 0; m_err = 0;
      if (dis_valid) begin
         if (m_st[dis_id] == 2) m_st[dis_id] = 0;
         else m_err = 1;
      end
      if (m_busy > 0) m_busy--;
      if (m_deq_left > 0) begin
         m_deq_left--;
         if (m_deq_left == 0) begin
            m_dv = 1;
            m_dp = m_inflight[WORD_W-1:ID_W];
            m_di = m_inflight[ID_W-1:0];
            m_st[m_di] = 2;
         end
      end
      if (grant) begin
         idx = pick_max(m_pq);
         m_inflight = m_pq[idx];
         m_pq.delete(idx);
         m_busy = 1 + DEQ_LAT; m_deq_left = 1 + DEQ_LAT;
         m_q_op = 1; m_q_ende = 1; m_pend = 0;
      end else begin
         if (doc_req) m_pend = 1;
         if (arr_valid && rdy) begin
            m_st[low] = 1;
            m_q_in = {arr_prio, ID_W'(low)};
            m_pq.push_back(m_q_in);
            m_q_op = 1; m_busy = 1;
         end
      end
   endtask

   task automatic step(input logic av, input logic [1:0] ap, input logic dr, input logic dv,
                       input logic [1:0] did);
      @(negedge clk);
      rst = 0; arr_valid = av; arr_prio = ap; doc_req = dr; dis_valid = dv; dis_id = did;
      #1;
      model_check();
      model_advance();
   endtask

   task automatic reset_dut(input int n);
      @(negedge clk);
      rst = 1; arr_valid = 0; doc_req = 0; dis_valid = 0;
      repeat (n) @(negedge clk);
      model_reset();
   endtask

   typedef struct {
      logic av; logic [1:0] ap; logic dr, dv; logic [1:0] did;
      logic rdy; logic [1:0] id; logic qop, qende; logic [3:0] qin;
      logic dvld; logic [1:0] dp, di; logic [2:0] occ, wt; logic full, err;
   } vec_t;

   localparam int NV = 17;
   vec_t tv[NV];

   initial begin
      //           av ap dr dv did  rdy id qop qe qin dv dp di occ wt full err
      tv[0]  = '{1, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
      tv[1]  = '{1, 2, 0, 0, 0,   0, 1, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0};
      tv[2]  = '{1, 2, 0, 0, 0,   1, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0};
      tv[3]  = '{1, 3, 0, 0, 0,   0, 2, 1, 0, 9,  0, 0, 0, 2, 2, 0, 0};
      tv[4]  = '{1, 3, 0, 0, 0,   1, 2, 0, 0, 0,  0, 0, 0, 2, 2, 0, 0};
      tv[5]  = '{1, 1, 0, 0, 0,   0, 3, 1, 0, 14, 0, 0, 0, 3, 3, 0, 0};
      tv[6]  = '{1, 1, 0, 0, 0,   1, 3, 0, 0, 0,  0, 0, 0, 3, 3, 0, 0};
      tv[7]  = '{1, 0, 0, 0, 0,   0, 0, 1, 0, 7,  0, 0, 0, 4, 4, 1, 0};
      tv[8]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 4, 4, 1, 0};
      tv[9]  = '{1, 0, 1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 4, 4, 1, 0};
      tv[10] = '{1, 0, 0, 0, 0,   0, 0, 1, 1, 0,  0, 0, 0, 4, 4, 1, 0};
      tv[11] = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 4, 4, 1, 0};
      tv[12] = '{0, 0, 0, 1, 2,   0, 0, 0, 0, 0,  1, 3, 2, 4, 3, 1, 0};
      tv[13] = '{1, 2, 0, 0, 0,   1, 2, 0, 0, 0,  0, 3, 2, 3, 3, 0, 0};
      tv[14] = '{0, 0, 0, 1, 0,   0, 0, 1, 0, 10, 0, 3, 2, 4, 4, 1, 0};
      tv[15] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 3, 2, 4, 4, 1, 1};
      tv[16] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 3, 2, 4, 4, 1, 0};

      reset_dut(2);
      chk("rst_q_op", q_op, 0);
      chk("rst_occ", occ_count, 0);
      chk("rst_disp_valid", disp_valid, 0);

      // Fill the room, overflow arrival, dispatch from a full room, discharge, bad discharge.
      for (int i = 0; i < NV; i++) begin
         step(tv[i].av, tv[i].ap, tv[i].dr, tv[i].dv, tv[i].did);
         chk($sformatf("tv%0d_arr_ready", i), arr_ready, tv[i].rdy);
         if (tv[i].rdy) chk($sformatf("tv%0d_arr_id", i), arr_id, tv[i].id);
         chk($sformatf("tv%0d_q_op", i), q_op, tv[i].qop);
         chk($sformatf("tv%0d_q_ende", i), q_ende, tv[i].qende);
         chk($sformatf("tv%0d_q_in", i), q_in, tv[i].qin);
         chk($sformatf("tv%0d_disp_valid", i), disp_valid, tv[i].dvld);
         chk($sformatf("tv%0d_disp_prio", i), disp_prio, tv[i].dp);
         chk($sformatf("tv%0d_disp_id", i), disp_id, tv[i].di);
         chk($sformatf("tv%0d_occ", i), occ_count, tv[i].occ);
         chk($sformatf("tv%0d_wait", i), wait_count, tv[i].wt);
         chk($sformatf("tv%0d_full", i), full, tv[i].full);
         chk($sformatf("tv%0d_err", i), err, tv[i].err);
      end

      // Doctor request on an empty queue is held and served right after the next enqueue.
      reset_dut(2);
      step(0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("pend_arr_ready", arr_ready, 1);
      chk("pend_arr_id", arr_id, 0);
      step(1, 2, 0, 0, 0);
      chk("pend_enq_op", q_op, 1);
      chk("pend_enq_ende", q_ende, 0);
      chk("pend_enq_word", q_in, 4'b0100);
      step(1, 2, 0, 0, 0);
      chk("pend_grant_stalls_arrival", arr_ready, 0);
      step(0, 0, 0, 0, 0);
      chk("pend_deq_op", q_op, 1);
      chk("pend_deq_ende", q_ende, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("pend_disp_valid", disp_valid, 1);
      chk("pend_disp_id", disp_id, 0);
      chk("pend_disp_prio", disp_prio, 1);
      chk("pend_wait", wait_count, 0);
      chk("pend_occ", occ_count, 1);

      // Reset while waiting on prioq: the late out word must not be dispatched.
      step(0, 0, 1, 0, 0);
      step(1, 3, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      reset_dut(1);
      chk("wrst_q_op", q_op, 0);
      chk("wrst_q_ende", q_ende, 0);
      chk("wrst_q_in", q_in, 0);
      chk("wrst_disp_valid", disp_valid, 0);
      chk("wrst_disp_prio", disp_prio, 0);
      chk("wrst_disp_id", disp_id, 0);
      chk("wrst_occ", occ_count, 0);
      chk("wrst_wait", wait_count, 0);
      chk("wrst_err", err, 0);
      step(0, 0, 0, 0, 0);
      chk("wrst_late_disp", disp_valid, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Random traffic against the reference model.
      reset_dut(2);
      for (int n = 0; n < 800; n++) begin
         int tr[$];
         logic [1:0] did;
         for (int i = 0; i < NUM_ID; i++) if (m_st[i] == 2) tr.push_back(i);
         if (tr.size() > 0 && $urandom_range(0, 3) != 0) did = 2'(tr[$urandom_range(0, tr.size() - 1)]);
         else did = 2'($urandom_range(0, 3));
         step($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 20, did);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
